// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared types and width constants for the DPLL solver blocks.
//   literal_t   : one clause literal slot {valid, neg, var_idx}
//   bcp_state_t : BCP engine scan states
//   SAT_*       : default widths, mirroring the solver's system definitions
// ---------------------------------------------------------------------------
package sat_pkg;

    localparam int unsigned SAT_MAX_VARS         = 256;
    localparam int unsigned SAT_MAX_VARS_BITS    = 8;
    localparam int unsigned SAT_MAX_CLAUSES_BITS = 10;
    localparam int unsigned SAT_LITS_PER_CLAUSE  = 3;
    localparam int unsigned SAT_LIT_BITS         = SAT_MAX_VARS_BITS + 2;
    localparam int unsigned SAT_CLAUSE_BITS      = SAT_LITS_PER_CLAUSE * SAT_LIT_BITS;

    // Slot i of a clause word occupies bits [i*SAT_LIT_BITS +: SAT_LIT_BITS].
    typedef struct packed {
        logic                         valid;
        logic                         neg;
        logic [SAT_MAX_VARS_BITS-1:0] var_idx;
    } literal_t;

    typedef enum logic [2:0] {
        BCP_IDLE,
        BCP_FETCH,
        BCP_EVAL,
        BCP_PUSH,
        BCP_DONE
    } bcp_state_t;

endpackage

// File: rtl/bcp_core_if.sv
// ---------------------------------------------------------------------------
// bcp_core_if
// Clause-memory read port and imply-queue push port of the BCP engine.
//   clause_read / clause_addr : read strobe and address (engine -> memory)
//   clause_data               : clause word, valid one cycle after clause_read
//   full_imply                : imply queue full (queue -> engine)
//   push_imply, var_in_imply, val_in_imply, type_in_imply : push (engine -> queue)
// Modports: master = BCP engine side, slave = memory/queue side.
// ---------------------------------------------------------------------------
interface bcp_core_if
    import sat_pkg::*;
#(
    parameter int unsigned MAX_VARS_BITS    = SAT_MAX_VARS_BITS,
    parameter int unsigned MAX_CLAUSES_BITS = SAT_MAX_CLAUSES_BITS,
    parameter int unsigned LITS_PER_CLAUSE  = SAT_LITS_PER_CLAUSE
);

    logic                                          clause_read;
    logic [MAX_CLAUSES_BITS-1:0]                   clause_addr;
    logic [LITS_PER_CLAUSE*(MAX_VARS_BITS+2)-1:0]  clause_data;
    logic                                          full_imply;
    logic                                          push_imply;
    logic [MAX_VARS_BITS-1:0]                      var_in_imply;
    logic                                          val_in_imply;
    logic                                          type_in_imply;

    modport master (
        output clause_read, clause_addr,
        input  clause_data,
        input  full_imply,
        output push_imply, var_in_imply, val_in_imply, type_in_imply
    );

    modport slave (
        input  clause_read, clause_addr,
        output clause_data,
        output full_imply,
        input  push_imply, var_in_imply, val_in_imply, type_in_imply
    );

endinterface

// File: rtl/bcp_core_clause_eval.sv
// ---------------------------------------------------------------------------
// clause_eval
// Purely combinational evaluation of one clause word against the variable
// state vectors.
//   clause_data            : LITS_PER_CLAUSE slots of {valid, neg, var}
//   vs_assigned, vs_value  : per-variable assigned flag and value
//   sat                    : some valid literal is true
//   conflict               : no true literal and no unassigned literal
//   unit                   : no true literal and exactly one unassigned literal
//   unit_var, unit_val     : variable and value forced by a unit clause
// ---------------------------------------------------------------------------
module clause_eval
    import sat_pkg::*;
#(
    parameter int unsigned MAX_VARS        = SAT_MAX_VARS,
    parameter int unsigned MAX_VARS_BITS   = SAT_MAX_VARS_BITS,
    parameter int unsigned LITS_PER_CLAUSE = SAT_LITS_PER_CLAUSE
) (
    input  logic [LITS_PER_CLAUSE*(MAX_VARS_BITS+2)-1:0] clause_data,
    input  logic [MAX_VARS-1:0]                          vs_assigned,
    input  logic [MAX_VARS-1:0]                          vs_value,
    output logic                                         sat,
    output logic                                         conflict,
    output logic                                         unit,
    output logic [MAX_VARS_BITS-1:0]                     unit_var,
    output logic                                         unit_val
);

    localparam int unsigned LIT_W = MAX_VARS_BITS + 2;

    logic                     lit_valid;
    logic                     lit_neg;
    logic [MAX_VARS_BITS-1:0] lit_var;
    logic [1:0]               n_free;   // unassigned literal count, saturates at 2
    logic                     any_true;

    always_comb begin
        lit_valid = 1'b0;
        lit_neg   = 1'b0;
        lit_var   = '0;
        n_free    = '0;
        any_true  = 1'b0;
        unit_var  = '0;
        unit_val  = 1'b0;
        for (int unsigned i = 0; i < LITS_PER_CLAUSE; i++) begin
            lit_valid = clause_data[i*LIT_W + LIT_W - 1];
            lit_neg   = clause_data[i*LIT_W + LIT_W - 2];
            lit_var   = clause_data[i*LIT_W +: MAX_VARS_BITS];
            if (lit_valid) begin
                if (vs_assigned[lit_var]) begin
                    if (vs_value[lit_var] != lit_neg) begin
                        any_true = 1'b1;
                    end
                end else begin
                    if (n_free != 2'd2) begin
                        n_free = n_free + 2'd1;
                    end
                    unit_var = lit_var;
                    unit_val = ~lit_neg;
                end
            end
        end
    end

    assign sat      = any_true;
    assign conflict = !any_true && (n_free == 2'd0);
    assign unit     = !any_true && (n_free == 2'd1);

endmodule

// File: rtl/bcp_core.sv
// ---------------------------------------------------------------------------
// bcp_core
// Boolean constraint propagation engine. Scans clauses start_clause..
// end_clause (inclusive), two cycles per clause (FETCH then EVAL), pushes
// unit implications into the imply queue and stops on the first all-false
// clause.
//   clock, reset         : clock, asynchronous active-low reset
//   start                : one-cycle pulse, accepted only when idle
//   start_clause/end_clause : scan range; empty range if end < start
//   reset_bcp            : synchronous abort, returns to idle
//   bcp_busy             : scan in progress
//   conflict             : last scan stopped on an all-false clause
//   bcp_clause_idx       : clause being scanned / conflicting clause
//   vs_assigned/vs_value : variable state (stable during a pass)
//   bus                  : clause memory read and imply queue push (master)
// Build option: BCP_DEDUP_EN keeps a per-pass pending-implication vector so
// that repeated implications are not pushed and contradicting ones become
// conflicts.
// ---------------------------------------------------------------------------
module bcp_core
    import sat_pkg::*;
#(
    parameter int unsigned MAX_VARS         = SAT_MAX_VARS,
    parameter int unsigned MAX_VARS_BITS    = SAT_MAX_VARS_BITS,
    parameter int unsigned MAX_CLAUSES_BITS = SAT_MAX_CLAUSES_BITS,
    parameter int unsigned LITS_PER_CLAUSE  = SAT_LITS_PER_CLAUSE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MAX_CLAUSES_BITS-1:0] start_clause,
    input  logic [MAX_CLAUSES_BITS-1:0] end_clause,
    input  logic                        reset_bcp,
    output logic                        bcp_busy,
    output logic                        conflict,
    output logic [MAX_CLAUSES_BITS-1:0] bcp_clause_idx,
    input  logic [MAX_VARS-1:0]         vs_assigned,
    input  logic [MAX_VARS-1:0]         vs_value,
    bcp_core_if.master                  bus
);

    bcp_state_t                  state_q, state_d;
    logic [MAX_CLAUSES_BITS-1:0] idx_q, idx_d;
    logic [MAX_CLAUSES_BITS-1:0] end_q, end_d;
    logic                        empty_q, empty_d;
    logic                        conflict_q, conflict_d;
    logic [MAX_VARS_BITS-1:0]    hold_var_q, hold_var_d;
    logic                        hold_val_q, hold_val_d;

    logic                        read;
    logic                        push;
    logic                        step;       // clause finished, move on
    logic [MAX_VARS_BITS-1:0]    push_var;
    logic                        push_val;

    logic [MAX_VARS-1:0]         eff_assigned;
    logic [MAX_VARS-1:0]         eff_value;

    logic                        ev_sat;
    logic                        ev_conflict;
    logic                        ev_unit;
    logic [MAX_VARS_BITS-1:0]    ev_var;
    logic                        ev_val;

`ifdef BCP_DEDUP_EN
    logic [MAX_VARS-1:0]         pend_set_q, pend_set_d;
    logic [MAX_VARS-1:0]         pend_val_q, pend_val_d;

    // Pending implications are folded into the evaluated variable state: a
    // repeated implication then reads as satisfied and a contradicting one
    // reads as a false literal, which yields the conflict at this clause.
    assign eff_assigned = vs_assigned | pend_set_q;
    assign eff_value    = (pend_set_q & pend_val_q) | (~pend_set_q & vs_value);
`else
    assign eff_assigned = vs_assigned;
    assign eff_value    = vs_value;
`endif

    clause_eval #(
        .MAX_VARS        (MAX_VARS),
        .MAX_VARS_BITS   (MAX_VARS_BITS),
        .LITS_PER_CLAUSE (LITS_PER_CLAUSE)
    ) u_eval (
        .clause_data (bus.clause_data),
        .vs_assigned (eff_assigned),
        .vs_value    (eff_value),
        .sat         (ev_sat),
        .conflict    (ev_conflict),
        .unit        (ev_unit),
        .unit_var    (ev_var),
        .unit_val    (ev_val)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= BCP_IDLE;
            idx_q      <= '0;
            end_q      <= '0;
            empty_q    <= 1'b0;
            conflict_q <= 1'b0;
            hold_var_q <= '0;
            hold_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            end_q      <= end_d;
            empty_q    <= empty_d;
            conflict_q <= conflict_d;
            hold_var_q <= hold_var_d;
            hold_val_q <= hold_val_d;
        end
    end

`ifdef BCP_DEDUP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_set_q <= '0;
            pend_val_q <= '0;
        end else begin
            pend_set_q <= pend_set_d;
            pend_val_q <= pend_val_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        end_d      = end_q;
        empty_d    = empty_q;
        conflict_d = conflict_q;
        hold_var_d = hold_var_q;
        hold_val_d = hold_val_q;
        read       = 1'b0;
        push       = 1'b0;
        step       = 1'b0;
        push_var   = ev_var;
        push_val   = ev_val;
`ifdef BCP_DEDUP_EN
        pend_set_d = pend_set_q;
        pend_val_d = pend_val_q;
`endif

        case (state_q)
            BCP_IDLE: begin
                if (start) begin
                    idx_d      = start_clause;
                    end_d      = end_clause;
                    empty_d    = (end_clause < start_clause);
                    conflict_d = 1'b0;
                    state_d    = BCP_FETCH;
`ifdef BCP_DEDUP_EN
                    pend_set_d = '0;
                    pend_val_d = '0;
`endif
                end
            end
            BCP_FETCH: begin
                // An empty range spends its single busy cycle here without
                // touching clause memory.
                read    = !empty_q;
                state_d = empty_q ? BCP_DONE : BCP_EVAL;
            end
            BCP_EVAL: begin
                if (ev_sat) begin
                    step = 1'b1;
                end else if (ev_conflict) begin
                    conflict_d = 1'b1;
                    state_d    = BCP_DONE;
                end else if (ev_unit) begin
`ifdef BCP_DEDUP_EN
                    pend_set_d[ev_var] = 1'b1;
                    pend_val_d[ev_var] = ev_val;
`endif
                    if (bus.full_imply) begin
                        hold_var_d = ev_var;
                        hold_val_d = ev_val;
                        state_d    = BCP_PUSH;
                    end else begin
                        push = 1'b1;
                        step = 1'b1;
                    end
                end else begin
                    step = 1'b1;
                end
            end
            BCP_PUSH: begin
                push_var = hold_var_q;
                push_val = hold_val_q;
                if (!bus.full_imply) begin
                    push = 1'b1;
                    step = 1'b1;
                end
            end
            BCP_DONE: begin
                state_d = BCP_IDLE;
            end
            default: begin
                state_d = BCP_IDLE;
            end
        endcase

        if (step) begin
            if (idx_q == end_q) begin
                state_d = BCP_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = BCP_FETCH;
            end
        end

        if (reset_bcp) begin
            state_d    = BCP_IDLE;
            conflict_d = 1'b0;
            push       = 1'b0;
        end
    end

    assign bcp_busy       = (state_q == BCP_FETCH) || (state_q == BCP_EVAL) ||
                            (state_q == BCP_PUSH);
    assign conflict       = conflict_q;
    assign bcp_clause_idx = idx_q;

    assign bus.clause_read   = read;
    assign bus.clause_addr   = read ? idx_q : '0;
    assign bus.push_imply    = push;
    assign bus.var_in_imply  = push ? push_var : '0;
    assign bus.val_in_imply  = push & push_val;
    assign bus.type_in_imply = push;

endmodule

// File: tb/tb_bcp_core.sv
// ---------------------------------------------------------------------------
// tb_bcp_core
// Self-checking bench for bcp_core: directed scenarios plus randomized
// passes compared against a clause-by-clause reference model. Honours the
// BCP_DEDUP_EN build option in both the model and the directed checks.
// ---------------------------------------------------------------------------
module tb_bcp_core;
    import sat_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [9:0]   start_clause;
    logic [9:0]   end_clause;
    logic         reset_bcp;
    logic         bcp_busy;
    logic         conflict;
    logic [9:0]   bcp_clause_idx;
    logic [255:0] vs_assigned;
    logic [255:0] vs_value;

    always #5 clock = ~clock;

    bcp_core_if #(
        .MAX_VARS_BITS    (8),
        .MAX_CLAUSES_BITS (10),
        .LITS_PER_CLAUSE  (3)
    ) bus ();

    bcp_core #(
        .MAX_VARS         (256),
        .MAX_VARS_BITS    (8),
        .MAX_CLAUSES_BITS (10),
        .LITS_PER_CLAUSE  (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .start_clause   (start_clause),
        .end_clause     (end_clause),
        .reset_bcp      (reset_bcp),
        .bcp_busy       (bcp_busy),
        .conflict       (conflict),
        .bcp_clause_idx (bcp_clause_idx),
        .vs_assigned    (vs_assigned),
        .vs_value       (vs_value),
        .bus            (bus)
    );

    // Clause memory: one-cycle read latency.
    logic [29:0] mem [0:1023];
    always @(posedge clock) begin
        if (bus.clause_read) bus.clause_data <= mem[bus.clause_addr];
    end

    int nvec = 0;
    int nerr = 0;

    typedef struct { int v; bit val; int cyc; } push_rec_t;
    push_rec_t push_q[$];
    int        read_cyc[$];
    int        r_busy, r_end_cyc, r_type_bad;

    typedef struct { int v; bit val; } imp_t;
    imp_t m_q[$];
    bit   m_conf;
    int   m_idx, m_visits;

    function automatic logic [9:0] lit(input bit neg, input int v);
        literal_t l;
        l.valid   = 1'b1;
        l.neg     = neg;
        l.var_idx = v[7:0];
        return l;
    endfunction

    function automatic logic [29:0] cl(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        return {c, b, a};
    endfunction

    // Reference: walk the range applying the literal rules directly.
    function automatic void model_pass(input int s, input int e);
        bit [255:0] pset = '0;
        bit [255:0] pval = '0;
        m_q.delete();
        m_conf = 0; m_idx = 0; m_visits = 0;
        for (int i = s; i <= e; i++) begin
            logic [29:0] w = mem[i];
            bit any_true = 0;
            int nfree = 0;
            int uv = 0;
            bit uval = 0;
            m_visits++;
            for (int k = 0; k < 3; k++) begin
                literal_t l;
                bit a, v;
                l = w[k*10 +: 10];
                if (!l.valid) continue;
                a = vs_assigned[l.var_idx];
                v = vs_value[l.var_idx];
`ifdef BCP_DEDUP_EN
                if (pset[l.var_idx]) begin a = 1; v = pval[l.var_idx]; end
`endif
                if (a) begin
                    if (v != l.neg) any_true = 1;
                end else begin
                    nfree++; uv = int'(l.var_idx); uval = !l.neg;
                end
            end
            if (any_true) continue;
            if (nfree == 0) begin m_conf = 1; m_idx = i; break; end
            if (nfree == 1) begin
                imp_t t;
                t.v = uv; t.val = uval;
                m_q.push_back(t);
                pset[uv] = 1; pval[uv] = uval;
            end
        end
    endfunction

    // full_mode: 0 never full, 1 full during cycles 2..4, 2 random.
    task automatic run_pass(input int s, input int e, input int full_mode, input int abort_cyc);
        bit done = 0;
        start_clause = 10'(s);
        end_clause   = 10'(e);
        push_q.delete();
        read_cyc.delete();
        r_busy = 0; r_end_cyc = 0; r_type_bad = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            case (full_mode)
                0:       bus.full_imply = 1'b0;
                1:       bus.full_imply = (cyc >= 2 && cyc <= 4);
                default: bus.full_imply = ($urandom_range(0, 2) == 0);
            endcase
            reset_bcp = (cyc == abort_cyc);
            @(negedge clock);
            if (bcp_busy) r_busy++;
            if (bus.clause_read) read_cyc.push_back(cyc);
            if (bus.push_imply) begin
                push_rec_t p;
                p.v = int'(bus.var_in_imply); p.val = bus.val_in_imply; p.cyc = cyc;
                push_q.push_back(p);
                if (bus.type_in_imply !== 1'b1) r_type_bad++;
            end
            if (!bcp_busy) begin r_end_cyc = cyc; done = 1; end
            @(posedge clock); #1 reset_bcp = 1'b0;
            if (done) break;
        end
        bus.full_imply = 1'b0;
        nvec++;
        if (!done) begin nerr++; $display("FAIL pass_timeout: busy never fell, required within 300 cycles"); end
    endtask

    logic [29:0] SAT_C, FALSE_C;

    task automatic set_base_vs();
        vs_assigned = '0; vs_value = '0;
        vs_assigned[0] = 1; vs_value[0] = 1;   // x0 = 1
        vs_assigned[1] = 1; vs_value[1] = 0;   // x1 = 0
        vs_assigned[5] = 1; vs_value[5] = 0;   // x5 = 0
        SAT_C   = cl(lit(0, 0), '0, '0);
        FALSE_C = cl(lit(0, 1), lit(1, 0), '0);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 0; reset_bcp = 0; bus.full_imply = 0;
        start_clause = '0; end_clause = '0; bus.clause_data = '0;
        #1;
        nvec++; if (bcp_busy !== 1'b0 || conflict !== 1'b0) begin nerr++; $display("FAIL reset_status: busy=%b conflict=%b, required 0 0", bcp_busy, conflict); end
        nvec++; if (bcp_clause_idx !== '0) begin nerr++; $display("FAIL reset_idx: got %0d required 0", bcp_clause_idx); end
        nvec++; if (bus.clause_read !== 0 || bus.clause_addr !== '0) begin nerr++; $display("FAIL reset_read: read=%b addr=%0d required 0 0", bus.clause_read, bus.clause_addr); end
        nvec++; if ({bus.push_imply, bus.var_in_imply, bus.val_in_imply, bus.type_in_imply} !== '0) begin nerr++; $display("FAIL reset_push: push=%b var=%0d val=%b type=%b required all 0", bus.push_imply, bus.var_in_imply, bus.val_in_imply, bus.type_in_imply); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_all_sat();
        for (int i = 0; i < 3; i++) mem[i] = SAT_C;
        run_pass(0, 2, 0, 0);
        nvec++; if (r_busy != 6) begin nerr++; $display("FAIL allsat_busy: got %0d cycles required 6", r_busy); end
        nvec++; if (conflict !== 1'b0) begin nerr++; $display("FAIL allsat_conflict: got %b required 0", conflict); end
        nvec++; if (push_q.size() != 0) begin nerr++; $display("FAIL allsat_push: got %0d pushes required 0", push_q.size()); end
    endtask

    task automatic test_unit_push();
        mem[0] = SAT_C;
        mem[1] = cl(lit(0, 5), lit(1, 7), '0);  // x5 | ~x7
        mem[2] = SAT_C;
        run_pass(0, 2, 0, 0);
        nvec++; if (push_q.size() != 1) begin nerr++; $display("FAIL unit_count: got %0d pushes required 1", push_q.size()); end
        else begin
            nvec++; if (push_q[0].v != 7 || push_q[0].val != 0 || r_type_bad != 0) begin nerr++; $display("FAIL unit_value: var=%0d val=%b badtype=%0d required 7 0 0", push_q[0].v, push_q[0].val, r_type_bad); end
            nvec++; if (push_q[0].cyc != 4) begin nerr++; $display("FAIL unit_cycle: got %0d required 4", push_q[0].cyc); end
        end
        nvec++; if (r_busy != 6 || read_cyc.size() != 3) begin nerr++; $display("FAIL unit_continue: busy=%0d reads=%0d required 6 3", r_busy, read_cyc.size()); end
    endtask

    task automatic test_conflict();
        for (int i = 0; i <= 10; i++) mem[i] = SAT_C;
        mem[3] = FALSE_C;
        run_pass(0, 10, 0, 0);
        nvec++; if (conflict !== 1'b1 || bcp_clause_idx !== 10'd3) begin nerr++; $display("FAIL conflict_idx: conflict=%b idx=%0d required 1 3", conflict, bcp_clause_idx); end
        nvec++; if (r_end_cyc != 9 || r_busy != 8) begin nerr++; $display("FAIL conflict_stop: busy low at %0d busy=%0d required 9 8", r_end_cyc, r_busy); end
        nvec++; if (read_cyc.size() != 4) begin nerr++; $display("FAIL conflict_reads: got %0d required 4", read_cyc.size()); end
    endtask

    task automatic test_full_stall();
        mem[0] = cl(lit(1, 7), '0, '0);
        mem[1] = SAT_C;
        run_pass(0, 1, 1, 0);
        nvec++; if (push_q.size() != 1) begin nerr++; $display("FAIL stall_count: got %0d pushes required 1", push_q.size()); end
        else begin
            nvec++; if (push_q[0].cyc != 5 || push_q[0].v != 7 || push_q[0].val != 0) begin nerr++; $display("FAIL stall_push: cyc=%0d var=%0d val=%b required 5 7 0", push_q[0].cyc, push_q[0].v, push_q[0].val); end
        end
        nvec++; if (read_cyc.size() != 2 || read_cyc[read_cyc.size()-1] != 6) begin nerr++; $display("FAIL stall_refetch: reads=%0d required 2 with second at cycle 6", read_cyc.size()); end
        nvec++; if (r_busy != 7) begin nerr++; $display("FAIL stall_busy: got %0d required 7", r_busy); end
    endtask

    task automatic test_empty_range();
        mem[3] = FALSE_C;
        run_pass(3, 3, 0, 0);
        nvec++; if (conflict !== 1'b1) begin nerr++; $display("FAIL single_conflict: got %b required 1", conflict); end
        run_pass(5, 2, 0, 0);
        nvec++; if (r_busy != 1 || read_cyc.size() != 0) begin nerr++; $display("FAIL empty_busy: busy=%0d reads=%0d required 1 0", r_busy, read_cyc.size()); end
        nvec++; if (conflict !== 1'b0 || push_q.size() != 0) begin nerr++; $display("FAIL empty_clear: conflict=%b pushes=%0d required 0 0", conflict, push_q.size()); end
    endtask

    task automatic test_abort();
        for (int i = 0; i <= 9; i++) mem[i] = SAT_C;
        mem[4] = cl(lit(1, 7), '0, '0);
        run_pass(0, 9, 0, 10);                  // cycle 10 is EVAL of clause 4
        nvec++; if (r_end_cyc != 11 || push_q.size() != 0) begin nerr++; $display("FAIL abort_stop: busy low at %0d pushes=%0d required 11 0", r_end_cyc, push_q.size()); end
        nvec++; if (conflict !== 1'b0) begin nerr++; $display("FAIL abort_conflict: got %b required 0", conflict); end
        // Asynchronous reset while fetching clause 1.
        start_clause = 0; end_clause = 9;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        nvec++; if (bcp_busy !== 1'b1 || bus.clause_addr !== 10'd1) begin nerr++; $display("FAIL midscan_pre: busy=%b addr=%0d required 1 1", bcp_busy, bus.clause_addr); end
        reset = 1'b0; #1;
        nvec++; if ({bcp_busy, conflict, bcp_clause_idx, bus.clause_read, bus.clause_addr, bus.push_imply, bus.var_in_imply, bus.val_in_imply, bus.type_in_imply} !== '0) begin nerr++; $display("FAIL midscan_reset: busy=%b idx=%0d read=%b addr=%0d required all 0", bcp_busy, bcp_clause_idx, bus.clause_read, bus.clause_addr); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_repeat_imply();
        vs_assigned[4] = 0;
        mem[0] = cl(lit(0, 4), '0, '0);
        mem[1] = cl(lit(0, 4), lit(0, 1), '0);
        run_pass(0, 1, 0, 0);
`ifdef BCP_DEDUP_EN
        nvec++; if (push_q.size() != 1) begin nerr++; $display("FAIL dedup_same: got %0d pushes required 1", push_q.size()); end
`else
        nvec++; if (push_q.size() != 2) begin nerr++; $display("FAIL dup_same: got %0d pushes required 2", push_q.size()); end
`endif
        mem[1] = cl(lit(1, 4), '0, '0);
        run_pass(0, 1, 0, 0);
`ifdef BCP_DEDUP_EN
        nvec++; if (conflict !== 1'b1 || bcp_clause_idx !== 10'd1 || push_q.size() != 1) begin nerr++; $display("FAIL dedup_opposite: conflict=%b idx=%0d pushes=%0d required 1 1 1", conflict, bcp_clause_idx, push_q.size()); end
`else
        nvec++; if (conflict !== 1'b0 || push_q.size() != 2) begin nerr++; $display("FAIL dup_opposite: conflict=%b pushes=%0d required 0 2", conflict, push_q.size()); end
`endif
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int s, e;
            vs_assigned = '0; vs_value = '0;
            for (int v = 0; v < 12; v++) begin
                vs_assigned[v] = ($urandom_range(0, 2) != 0);
                vs_value[v]    = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 24; i++) begin
                logic [29:0] w = '0;
                for (int k = 0; k < 3; k++)
                    if ($urandom_range(0, 3) != 0)
                        w[k*10 +: 10] = lit(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)));
                mem[i] = w;
            end
            s = int'($urandom_range(0, 15));
            e = ($urandom_range(0, 7) == 0 && s > 0) ? s - 1 : s + int'($urandom_range(0, 7));
            model_pass(s, e);
            run_pass(s, e, 2, 0);
            nvec++; if (conflict !== m_conf) begin nerr++; $display("FAIL rand_conflict[%0d]: got %b required %b", t, conflict, m_conf); end
            if (m_conf) begin
                nvec++; if (bcp_clause_idx !== 10'(m_idx)) begin nerr++; $display("FAIL rand_idx[%0d]: got %0d required %0d", t, bcp_clause_idx, m_idx); end
            end
            nvec++; if (read_cyc.size() != m_visits) begin nerr++; $display("FAIL rand_reads[%0d]: got %0d required %0d", t, read_cyc.size(), m_visits); end
            nvec++;
            if (push_q.size() != m_q.size() || r_type_bad != 0) begin
                nerr++; $display("FAIL rand_pushes[%0d]: got %0d (badtype %0d) required %0d", t, push_q.size(), r_type_bad, m_q.size());
            end else begin
                for (int j = 0; j < m_q.size(); j++) begin
                    nvec++;
                    if (push_q[j].v != m_q[j].v || push_q[j].val != m_q[j].val) begin
                        nerr++; $display("FAIL rand_push[%0d.%0d]: got var=%0d val=%b required var=%0d val=%b", t, j, push_q[j].v, push_q[j].val, m_q[j].v, m_q[j].val);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        set_base_vs();
        test_reset();
        test_all_sat();
        test_unit_push();
        test_conflict();
        test_full_stall();
        test_empty_range();
        test_abort();
        test_repeat_imply();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
